// File: rtl/flash_playback_sequencer.sv
// ============================================================================
// Module   : flash_playback_sequencer
// Brief    : Fetches 32-bit words from the audio flash (Avalon-MM read) and
//            plays the two 16-bit samples of each word, one per sample tick.
//            Optional macro LOOP_EN: wrap at the image ends and keep playing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flash_playback_sequencer #(
  parameter int                ADDR_W    = 23,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              fwd_i,
  input  logic              bwd_i,
  input  logic              restart_i,
  input  logic              sample_tick_i,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic [31:0]       flash_readdata,
  input  logic              flash_readdatavalid,
  output logic [15:0]       audio_data,
  output logic              audio_valid,
  output logic              playing,
  output logic              dir_bw
);

`ifdef LOOP_EN
  localparam logic c_LOOP_EN = 1'b1;
`else
  localparam logic c_LOOP_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_DATA = 3'd2,
    ST_HALF0     = 3'd3,
    ST_HALF1     = 3'd4
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_dir_bw;
  logic [31:0]         r_word;
  logic                r_word_bw;
  logic                r_stop_pend;
  logic                r_restart_pend;
  logic [15:0]         r_audio_data;
  logic                r_audio_valid;

  // Same-cycle priority: restart beats stop beats start.
  logic w_restart_cmd;
  logic w_stop_cmd;
  logic w_start_cmd;
  logic w_restart_eff;
  logic w_stop_eff;
  logic [ADDR_W-1:0] w_reload_addr;
  logic [ADDR_W-1:0] w_step_addr;
  logic [ADDR_W-1:0] w_next_addr;
  logic w_at_end;
  logic w_end_stop;

  assign w_restart_cmd = restart_i;
  assign w_stop_cmd    = stop_i & ~restart_i;
  assign w_start_cmd   = start_i & ~restart_i & ~stop_i;
  assign w_restart_eff = r_restart_pend | w_restart_cmd;
  assign w_stop_eff    = (r_stop_pend | w_stop_cmd) & ~w_start_cmd;

  // Running off either end of the image reloads the same address a restart would.
  assign w_reload_addr = r_dir_bw ? LAST_ADDR : '0;
  assign w_at_end      = r_dir_bw ? (r_addr == '0) : (r_addr == LAST_ADDR);
  assign w_step_addr   = r_dir_bw ? (r_addr - 1'b1) : (r_addr + 1'b1);
  assign w_next_addr   = (w_restart_eff | w_at_end) ? w_reload_addr : w_step_addr;
  assign w_end_stop    = w_at_end & ~w_restart_eff & ~c_LOOP_EN;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_addr         <= '0;
      r_dir_bw       <= 1'b0;
      r_word         <= '0;
      r_word_bw      <= 1'b0;
      r_stop_pend    <= 1'b0;
      r_restart_pend <= 1'b0;
      r_audio_data   <= '0;
      r_audio_valid  <= 1'b0;
    end else begin
      r_audio_valid <= 1'b0;

      if (fwd_i & ~bwd_i) begin
        r_dir_bw <= 1'b0;
      end else if (bwd_i & ~fwd_i) begin
        r_dir_bw <= 1'b1;
      end

      if (r_state == ST_IDLE) begin
        if (w_restart_cmd) begin
          r_addr <= w_reload_addr;
        end else if (w_start_cmd) begin
          r_state <= ST_FETCH;
        end
      end else begin
        r_restart_pend <= w_restart_eff;
        r_stop_pend    <= w_stop_eff;

        case (r_state)
          ST_FETCH: begin
            if (!flash_waitrequest) begin
              r_state <= ST_WAIT_DATA;
            end
          end
          ST_WAIT_DATA: begin
            if (flash_readdatavalid) begin
              r_word    <= flash_readdata;
              r_word_bw <= r_dir_bw;
              r_state   <= ST_HALF0;
            end
          end
          ST_HALF0: begin
            if (sample_tick_i) begin
              r_audio_data  <= r_word_bw ? r_word[31:16] : r_word[15:0];
              r_audio_valid <= 1'b1;
              r_state       <= ST_HALF1;
            end
          end
          ST_HALF1: begin
            if (sample_tick_i) begin
              r_audio_data   <= r_word_bw ? r_word[15:0] : r_word[31:16];
              r_audio_valid  <= 1'b1;
              r_addr         <= w_next_addr;
              r_restart_pend <= 1'b0;
              r_stop_pend    <= 1'b0;
              r_state        <= (w_stop_eff | w_end_stop) ? ST_IDLE : ST_FETCH;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign flash_read    = (r_state == ST_FETCH);
  assign flash_address = r_addr;
  assign audio_data    = r_audio_data;
  assign audio_valid   = r_audio_valid;
  assign playing       = (r_state != ST_IDLE);
  assign dir_bw        = r_dir_bw;

endmodule

`default_nettype wire
